// File: rtl/out_port_capture.sv
// Output-port capture FIFO: records words the processor strobes onto its output
// bus, presents them first-word-fall-through, and reports completion once the
// processor halts and every captured word has been consumed.
//
// Build option: define OUTPORT_WATCHDOG_EN to add a RUN-state cycle watchdog
// that forces the drain phase after WDOG_CYCLES edges; otherwise timeout is 0.
module out_port_capture #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WDOG_CYCLES = 1000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [WIDTH-1:0]         bus,
    input  logic                     bus_enable,
    input  logic                     halt,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     timeout
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [AW:0]   CntOne  = (AW+1)'(1);
    localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic in_run;
    logic full;
    logic push;
    logic pop;
    logic drop;
    logic wdog_fire;

    assign in_run    = (state_q == StRun);
    assign full      = (count_q == CntFull);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
    assign push      = bus_enable & in_run & (~full | pop);
    assign drop      = bus_enable & in_run & full & ~pop;

    assign out_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign done     = (state_q == StDone);

`ifdef OUTPORT_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WdogOne   = WW'(1);
    localparam logic [WW-1:0] WdogLimit = WW'(WDOG_CYCLES);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_q;

    // Count edges spent in RUN; fire on the edge that reaches the limit.
    always_comb begin
        wdog_d    = in_run ? (wdog_q + WdogOne) : wdog_q;
        wdog_fire = in_run && (wdog_d == WdogLimit);
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_q | wdog_fire;
        end
    end

    assign timeout = timeout_q;
`else
    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Occupancy next state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // RUN -> DRAIN on halt or watchdog; DRAIN -> DONE once the FIFO is empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (halt || wdog_fire) state_d = StDrain;
            StDrain: if (count_d == '0) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StRun;
        endcase
    end

    // Control state: FSM, pointers, occupancy and sticky overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StRun;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | drop;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Storage array; contents are don't-care while empty, so it is not reset.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus;
    end

endmodule

// File: tb/tb_out_port_capture.sv
// Directed bench for out_port_capture (WIDTH=16, DEPTH=16).
module tb_out_port_capture;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 16;

    logic             clock;
    logic             resetn;
    logic [WIDTH-1:0] bus;
    logic             bus_enable;
    logic             halt;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [4:0]       count;
    logic             overflow;
    logic             done;
    logic             timeout;

    int n_checks;
    int n_errors;

    out_port_capture #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .WDOG_CYCLES (1000)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus),
        .bus_enable (bus_enable),
        .halt       (halt),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow),
        .done       (done),
        .timeout    (timeout)
    );

`ifdef OUTPORT_WATCHDOG_EN
    logic [WIDTH-1:0] wd_out_data;
    logic             wd_out_valid;
    logic [4:0]       wd_count;
    logic             wd_overflow;
    logic             wd_done;
    logic             wd_timeout;

    out_port_capture #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .WDOG_CYCLES (10)
    ) dut_wd (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus),
        .bus_enable (bus_enable),
        .halt       (halt),
        .out_data   (wd_out_data),
        .out_valid  (wd_out_valid),
        .out_ready  (out_ready),
        .count      (wd_count),
        .overflow   (wd_overflow),
        .done       (wd_done),
        .timeout    (wd_timeout)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic [WIDTH-1:0] val, input logic rdy);
        bus_enable = en;
        bus        = val;
        out_ready  = rdy;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn     = 1'b0;
        halt       = 1'b0;
        drive(1'b0, '0, 1'b0);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_timeout", 32'(timeout), 0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        resetn     = 1'b0;
        halt       = 1'b0;
        drive(1'b0, '0, 1'b0);
        #12;
        apply_reset();

        // Basic push/pop; first edge after reset captures.
        drive(1'b1, 16'd5, 1'b1);
        step();
        check("basic_d5", 32'(out_data), 5);
        check("basic_c1", 32'(count), 1);
        drive(1'b1, 16'd7, 1'b1);
        step();
        check("basic_d7", 32'(out_data), 7);
        check("basic_c2", 32'(count), 1);
        drive(1'b1, 16'd9, 1'b1);
        step();
        check("basic_d9", 32'(out_data), 9);
        check("basic_c3", 32'(count), 1);
        drive(1'b0, '0, 1'b1);
        step();
        check("basic_empty_cnt", 32'(count), 0);
        check("basic_empty_vld", 32'(out_valid), 0);
        // out_ready while empty has no effect.
        step();
        check("ready_empty_cnt", 32'(count), 0);

        // Fill 16, overflow on the 17th, drain 1..16.
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            step();
        end
        check("fill_cnt", 32'(count), 16);
        check("fill_ovf0", 32'(overflow), 0);
        drive(1'b1, 16'd17, 1'b0);
        step();
        check("ovf_cnt", 32'(count), 16);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_head", 32'(out_data), 1);
        for (int i = 1; i <= 16; i++) begin
            check("drain1_data", 32'(out_data), 32'(i));
            drive(1'b0, '0, 1'b1);
            step();
        end
        check("drain1_cnt", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Push while full with a simultaneous pop.
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            step();
        end
        drive(1'b1, 16'd100, 1'b1);
        step();
        check("fullpp_cnt", 32'(count), 16);
        check("fullpp_ovf", 32'(overflow), 0);
        for (int i = 2; i <= 17; i++) begin
            check("drain2_data", 32'(out_data), (i == 17) ? 32'd100 : 32'(i));
            drive(1'b0, '0, 1'b1);
            step();
        end
        check("drain2_cnt", 32'(count), 0);

        // Pointer wrap: 40 words, each pushed then popped.
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            step();
            check("wrap_data", 32'(out_data), 32'(i));
            drive(1'b0, '0, 1'b1);
            step();
        end
        check("wrap_cnt", 32'(count), 0);
        check("wrap_ovf", 32'(overflow), 0);

        // Halt with a simultaneous push; later words ignored.
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            step();
        end
        halt = 1'b1;
        drive(1'b1, 16'd4, 1'b0);
        step();
        check("halt_cnt4", 32'(count), 4);
        check("halt_done0", 32'(done), 0);
        drive(1'b1, 16'd50, 1'b0);
        step();
        check("halt_ignore", 32'(count), 4);
        check("halt_ignore_ovf", 32'(overflow), 0);
        for (int i = 1; i <= 4; i++) begin
            check("halt_data", 32'(out_data), 32'(i));
            check("halt_done_early", 32'(done), 0);
            drive(1'b1, 16'd60, 1'b1);
            step();
        end
        check("halt_done", 32'(done), 1);
        check("halt_final_cnt", 32'(count), 0);
        check("halt_final_vld", 32'(out_valid), 0);

        // Halt with the FIFO empty: done two edges later, then terminal.
        apply_reset();
        halt = 1'b1;
        step();
        check("hempty_done_e1", 32'(done), 0);
        step();
        check("hempty_done_e2", 32'(done), 1);
        halt = 1'b0;
        drive(1'b1, 16'd77, 1'b0);
        step();
        check("done_terminal", 32'(done), 1);
        check("done_no_push", 32'(count), 0);

        // Mid-operation reset with 6 words stored.
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            step();
        end
        check("mid_pre_cnt", 32'(count), 6);
        drive(1'b0, '0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_cnt", 32'(count), 0);
        check("mid_vld", 32'(out_valid), 0);
        check("mid_done", 32'(done), 0);
        @(negedge clock);
        resetn = 1'b1;
        check("timeout_off", 32'(timeout), 0);

`ifdef OUTPORT_WATCHDOG_EN
        // Watchdog at 10 edges without halt.
        apply_reset();
        for (int i = 1; i <= 8; i++) step();
        drive(1'b1, 16'd11, 1'b0);
        step();
        check("wd_t0", 32'(wd_timeout), 0);
        drive(1'b1, 16'd12, 1'b0);
        step();
        check("wd_t1", 32'(wd_timeout), 1);
        check("wd_cnt", 32'(wd_count), 2);
        drive(1'b1, 16'd13, 1'b0);
        step();
        check("wd_ignore", 32'(wd_count), 2);
        check("wd_done0", 32'(wd_done), 0);
        check("wd_d11", 32'(wd_out_data), 11);
        drive(1'b0, '0, 1'b1);
        step();
        check("wd_d12", 32'(wd_out_data), 12);
        step();
        check("wd_done", 32'(wd_done), 1);
        check("wd_sticky", 32'(wd_timeout), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
